// File: rtl/traffic_light_monitor.sv
// Passive checker beside traffic_controller: flags right-of-way conflicts,
// illegal colour moves, short green/yellow phases and all-red stalls.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   light_M1/Mt/M2/S [2:0]        observed lights {R,Y,G}
//   err_clr                       clears sticky flags and err_road
//   err_conflict/sequence/timing/stall  sticky error flags
//   err_any                       OR of the four flags
//   err_road [3:0]                sticky blame {S,M2,Mt,M1}
//   green_cnt [CNT_W-1:0]         M1 red->green entries (wraps)
//   first_err_code/time           only with FIRST_ERR_LOG_EN defined
module traffic_light_monitor #(
    parameter int MIN_GREEN  = 10,
    parameter int MIN_YELLOW = 3,
    parameter int MAX_ALLRED = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_Mt,
    input  logic [2:0]       light_M2,
    input  logic [2:0]       light_S,
    input  logic             err_clr,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_timing,
    output logic             err_stall,
    output logic             err_any,
    output logic [3:0]       err_road,
    output logic [CNT_W-1:0] green_cnt
`ifdef FIRST_ERR_LOG_EN
    ,
    output logic [2:0]       first_err_code,
    output logic [15:0]      first_err_time
`endif
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_AR = CNT_W'(MAX_ALLRED);
    localparam logic [CNT_W-1:0] SAT    = '1;

    logic [2:0]       cur    [4];
    logic [2:0]       prev_q [4];
    logic [CNT_W-1:0] dur_q  [4];
    logic [CNT_W-1:0] dur_d  [4];
    logic [CNT_W-1:0] allred_q, allred_d;
    logic [CNT_W-1:0] green_q, green_d;

    logic con_q, seq_q, tim_q, stl_q;
    logic con_d, seq_d, tim_d, stl_d;
    logic [3:0] road_q, road_d;

    logic [3:0] nonred;
    logic [3:0] con_bit, seq_bit, tim_bit;
    logic       stall_det;

    assign cur[0] = light_M1;
    assign cur[1] = light_Mt;
    assign cur[2] = light_M2;
    assign cur[3] = light_S;

    always_comb begin
        nonred  = '0;
        seq_bit = '0;
        tim_bit = '0;
        for (int i = 0; i < 4; i++) begin
            dur_d[i]  = '0;
            nonred[i] = (cur[i] != RED);
            if (!(cur[i] == RED || cur[i] == YEL || cur[i] == GRN)) begin
                seq_bit[i] = 1'b1;
            end else if (prev_q[i] == RED || prev_q[i] == YEL ||
                         prev_q[i] == GRN) begin
                // A non-one-hot previous value is treated as no colour,
                // so it skips both move and duration checks.
                if ((prev_q[i] == GRN && cur[i] == RED) ||
                    (prev_q[i] == YEL && cur[i] == GRN) ||
                    (prev_q[i] == RED && cur[i] == YEL))
                    seq_bit[i] = 1'b1;
                if (prev_q[i] == GRN && cur[i] == YEL && dur_q[i] < MIN_G)
                    tim_bit[i] = 1'b1;
                if (prev_q[i] == YEL && cur[i] == RED && dur_q[i] < MIN_Y)
                    tim_bit[i] = 1'b1;
            end
            if (cur[i] != prev_q[i])
                dur_d[i] = CNT_W'(1);
            else if (dur_q[i] == SAT)
                dur_d[i] = dur_q[i];
            else
                dur_d[i] = dur_q[i] + CNT_W'(1);
        end
    end

    // Pairs M1/S, Mt/M2, Mt/S, M2/S; each offending pair blames both roads.
    always_comb begin
        con_bit = '0;
        if (nonred[0] && nonred[3]) con_bit = con_bit | 4'b1001;
        if (nonred[1] && nonred[2]) con_bit = con_bit | 4'b0110;
        if (nonred[1] && nonred[3]) con_bit = con_bit | 4'b1010;
        if (nonred[2] && nonred[3]) con_bit = con_bit | 4'b1100;
    end

    always_comb begin
        if (nonred != 4'b0000)
            allred_d = '0;
        else if (allred_q == SAT)
            allred_d = allred_q;
        else
            allred_d = allred_q + CNT_W'(1);
        stall_det = (allred_d > MAX_AR);
    end

    always_comb begin
        green_d = green_q;
        if (prev_q[0] == RED && cur[0] == GRN)
            green_d = green_q + CNT_W'(1);
    end

    // A detection in the clearing cycle wins over err_clr.
    always_comb begin
        con_d  = (con_q & ~err_clr) | (|con_bit);
        seq_d  = (seq_q & ~err_clr) | (|seq_bit);
        tim_d  = (tim_q & ~err_clr) | (|tim_bit);
        stl_d  = (stl_q & ~err_clr) | stall_det;
        road_d = (err_clr ? 4'b0000 : road_q) | con_bit | seq_bit | tim_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i] <= RED;
                dur_q[i]  <= '0;
            end
            allred_q <= '0;
            green_q  <= '0;
            con_q    <= 1'b0;
            seq_q    <= 1'b0;
            tim_q    <= 1'b0;
            stl_q    <= 1'b0;
            road_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i] <= cur[i];
                dur_q[i]  <= dur_d[i];
            end
            allred_q <= allred_d;
            green_q  <= green_d;
            con_q    <= con_d;
            seq_q    <= seq_d;
            tim_q    <= tim_d;
            stl_q    <= stl_d;
            road_q   <= road_d;
        end
    end

    assign err_conflict = con_q;
    assign err_sequence = seq_q;
    assign err_timing   = tim_q;
    assign err_stall    = stl_q;
    assign err_any      = con_q | seq_q | tim_q | stl_q;
    assign err_road     = road_q;
    assign green_cnt    = green_q;

`ifdef FIRST_ERR_LOG_EN
    logic [15:0] cyc_q;
    logic [2:0]  code_q, code_d;
    logic [15:0] time_q, time_d;

    // Capture is armed while the code is zero; a clear re-arms it and a
    // detection in the clearing cycle is captured immediately.
    always_comb begin
        code_d = err_clr ? 3'd0 : code_q;
        time_d = err_clr ? 16'd0 : time_q;
        if (code_d == 3'd0 &&
            ((|con_bit) || (|seq_bit) || (|tim_bit) || stall_det)) begin
            time_d = cyc_q;
            if (|con_bit)      code_d = 3'd1;
            else if (|seq_bit) code_d = 3'd2;
            else if (|tim_bit) code_d = 3'd3;
            else               code_d = 3'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= '0;
            code_q <= '0;
            time_q <= '0;
        end else begin
            cyc_q  <= cyc_q + 16'd1;
            code_q <= code_d;
            time_q <= time_d;
        end
    end

    assign first_err_code = code_q;
    assign first_err_time = time_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: legal cycle, conflicts,
// sequence/timing/stall errors, err_clr priority and mid-run reset.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_Mt, light_M2, light_S;
    logic       err_clr;
    logic       err_conflict, err_sequence, err_timing, err_stall, err_any;
    logic [3:0] err_road;
    logic [7:0] green_cnt;

    int errors = 0;
    int checks = 0;

    traffic_light_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .light_M1     (light_M1),
        .light_Mt     (light_Mt),
        .light_M2     (light_M2),
        .light_S      (light_S),
        .err_clr      (err_clr),
        .err_conflict (err_conflict),
        .err_sequence (err_sequence),
        .err_timing   (err_timing),
        .err_stall    (err_stall),
        .err_any      (err_any),
        .err_road     (err_road),
        .green_cnt    (green_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d);
        light_M1 = a;
        light_Mt = b;
        light_M2 = c;
        light_S  = d;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic hold(input int n, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d);
        for (int k = 0; k < n; k++) step(a, b, c, d);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        err_clr = 1'b0;
        step(R, R, R, R);
        step(R, R, R, R);
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {conflict,sequence,timing,stall,any}.
    task automatic chk_all(input string tag, input logic [4:0] f,
                           input logic [3:0] road);
        chk({tag, ".flags"},
            32'({err_conflict, err_sequence, err_timing, err_stall, err_any}),
            32'(f));
        chk({tag, ".road"}, 32'(err_road), 32'(road));
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        light_M1 = R; light_Mt = R; light_M2 = R; light_S = R;

        // Reset state
        do_reset();
        chk_all("reset", 5'b00000, 4'b0000);
        chk("reset.green_cnt", 32'(green_cnt), 32'd0);

        // 1: legal full cycle
        hold(2, R, R, R, R);
        hold(10, G, R, G, R);
        chk("legal.green_cnt", 32'(green_cnt), 32'd1);
        hold(3, Y, R, Y, R);
        hold(4, R, R, R, R);
        hold(10, R, R, R, G);
        hold(3, R, R, R, Y);
        hold(4, R, R, R, R);
        chk_all("legal", 5'b00000, 4'b0000);
        chk("legal.green_cnt_end", 32'(green_cnt), 32'd1);

        // 2: M1/S conflict
        do_reset();
        step(G, R, R, G);
        chk_all("conf_m1s", 5'b10001, 4'b1001);
        chk("conf_m1s.green_cnt", 32'(green_cnt), 32'd1);

        // Mt/M2 conflict
        do_reset();
        step(R, G, G, R);
        chk_all("conf_mtm2", 5'b10001, 4'b0110);

        // M1/Mt legal together
        do_reset();
        step(G, G, R, R);
        chk_all("m1mt_legal", 5'b00000, 4'b0000);

        // Conflict plus illegal R->Y on S in one cycle
        do_reset();
        step(G, R, R, Y);
        chk_all("conf_seq", 5'b11001, 4'b1001);

        // 3: M2 G 12 then straight to red
        do_reset();
        hold(12, R, R, G, R);
        chk_all("m2_green", 5'b00000, 4'b0000);
        step(R, R, R, R);
        chk_all("g_to_r", 5'b01001, 4'b0100);

        // Non-one-hot on S, then exit from it is not an error
        do_reset();
        step(R, R, R, 3'b011);
        chk_all("nonhot", 5'b01001, 4'b1000);
        err_clr = 1'b1;
        step(R, R, R, R);
        chk_all("nonhot_exit", 5'b00000, 4'b0000);

        // 4: Mt yellow too short
        do_reset();
        hold(10, R, G, R, R);
        hold(2, R, Y, R, R);
        chk_all("mt_y2", 5'b00000, 4'b0000);
        step(R, R, R, R);
        chk_all("mt_short_y", 5'b00101, 4'b0010);

        // Mt yellow exactly minimum
        do_reset();
        hold(10, R, G, R, R);
        hold(3, R, Y, R, R);
        step(R, R, R, R);
        chk_all("mt_y3", 5'b00000, 4'b0000);

        // M1 green one short of minimum
        do_reset();
        hold(9, G, R, R, R);
        step(Y, R, R, R);
        chk_all("m1_short_g", 5'b00101, 4'b0001);

        // 5: stall boundary
        do_reset();
        hold(8, R, R, R, R);
        step(G, R, R, R);
        chk_all("allred8", 5'b00000, 4'b0000);
        hold(9, G, R, R, R);
        hold(3, Y, R, R, R);
        hold(8, R, R, R, R);
        chk_all("allred8b", 5'b00000, 4'b0000);
        step(R, R, R, R);
        chk_all("allred9", 5'b00011, 4'b0000);

        // 6: clear versus new conflict in the same cycle
        do_reset();
        step(G, R, R, G);
        chk_all("c6_conf", 5'b10001, 4'b1001);
        err_clr = 1'b1;
        step(G, R, R, G);
        chk_all("c6_clr_conf", 5'b10001, 4'b1001);
        step(G, R, R, 3'b111);
        chk_all("c6_nonhot", 5'b11001, 4'b1001);
        err_clr = 1'b1;
        step(G, R, R, R);
        chk_all("c6_clr", 5'b00000, 4'b0000);
        chk("c6.green_cnt", 32'(green_cnt), 32'd1);

        // Reset in the middle of an error
        step(G, R, R, G);
        chk_all("c6_conf2", 5'b10001, 4'b1001);
        rst = 1'b1;
        step(G, R, R, G);
        chk_all("c6_rst", 5'b00000, 4'b0000);
        chk("c6_rst.green_cnt", 32'(green_cnt), 32'd0);
        rst = 1'b0;

        // First inputs after reset are compared against red
        step(Y, R, R, R);
        chk_all("post_rst_ry", 5'b01001, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
